// File: rtl/uart_tx_ctrl.sv
// UART TX frame sequencer: start, LSB-first data, optional parity, stop.
// One clk per bit; drives the downstream output mux select and the bit sources.
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [1:0]            mux_sel,
    output logic                  ser_data,
    output logic                  par_bit,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    localparam logic [1:0] SEL_START  = 2'b00;
    localparam logic [1:0] SEL_STOP   = 2'b01;
    localparam logic [1:0] SEL_DATA   = 2'b10;
    localparam logic [1:0] SEL_PARITY = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [DATA_WIDTH-1:0] r_data;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_par_en;
    logic                  r_par_bit;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: default assignment first so no path through the case leaves
    // w_next unassigned, which would infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (Data_Valid) w_next = S_START;
            S_START:  w_next = S_DATA;
            S_DATA:   if (r_cnt == LAST_BIT) w_next = r_par_en ? S_PARITY : S_STOP;
            S_PARITY: w_next = S_STOP;
            S_STOP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Inputs are captured only on acceptance, so later changes cannot leak into the frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data    <= '0;
            r_cnt     <= '0;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Data_Valid) begin
                        r_data    <= P_DATA;
                        r_par_en  <= PAR_EN;
                        r_par_bit <= (^P_DATA) ^ PAR_TYP;
                    end
                end
                S_START: r_cnt <= '0;
                S_DATA: begin
                    r_data <= r_data >> 1;
                    r_cnt  <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mux_sel  = SEL_STOP;
        busy     = 1'b0;
        ser_data = 1'b0;
        case (r_state)
            S_START: begin
                mux_sel = SEL_START;
                busy    = 1'b1;
            end
            S_DATA: begin
                mux_sel  = SEL_DATA;
                busy     = 1'b1;
                ser_data = r_data[0];
            end
            S_PARITY: begin
                mux_sel = SEL_PARITY;
                busy    = 1'b1;
            end
            S_STOP: begin
                mux_sel = SEL_STOP;
                busy    = 1'b1;
            end
            default: ;
        endcase
    end

    assign par_bit = r_par_bit;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: stimulus queues expected per-bit-cycle
// outputs, a negedge monitor pops and compares while busy is high.
module tb_uart_tx_ctrl;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] P_DATA;
    logic          Data_Valid;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic [1:0]    mux_sel;
    logic          ser_data;
    logic          par_bit;
    logic          busy;

    uart_tx_ctrl #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .mux_sel    (mux_sel),
        .ser_data   (ser_data),
        .par_bit    (par_bit),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] sel;
        logic       ser;
        logic       chk_ser;
        logic       par;
        int         gap;
    } item_t;

    item_t sb_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    idle_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [1:0] sel, input logic ser, input logic chk_ser,
                        input logic par, input int gap);
        item_t it;
        it.sel = sel; it.ser = ser; it.chk_ser = chk_ser; it.par = par; it.gap = gap;
        sb_q.push_back(it);
    endtask

    task automatic push_frame(input logic [DW-1:0] d, input logic pen, input logic par, input int gap);
        push(2'b00, 1'b0, 1'b0, par, gap);
        for (int i = 0; i < DW; i++) push(2'b10, d[i], 1'b1, par, -1);
        if (pen) push(2'b11, 1'b0, 1'b0, par, -1);
        push(2'b01, 1'b0, 1'b0, par, -1);
    endtask

    // Monitor: every busy cycle must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            if (busy) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_busy", 32'(busy), 32'd0);
                end else begin
                    item_t it;
                    it = sb_q.pop_front();
                    check("mux_sel", 32'(mux_sel), 32'(it.sel));
                    check("par_bit", 32'(par_bit), 32'(it.par));
                    if (it.chk_ser) check("ser_data", 32'(ser_data), 32'(it.ser));
                    if (it.gap >= 0 && it.sel == 2'b00) check("idle_gap", 32'(idle_cnt), 32'(it.gap));
                end
                idle_cnt = 0;
            end else begin
                check("idle_sel", 32'(mux_sel), 32'd1);
                idle_cnt++;
            end
        end
    end

    task automatic send_frame(input logic [DW-1:0] d, input logic pen, input logic ptyp, input logic par);
        push_frame(d, pen, par, -1);
        P_DATA = d; PAR_EN = pen; PAR_TYP = ptyp; Data_Valid = 1'b1;
        @(posedge clk); #1;
        Data_Valid = 1'b0; P_DATA = ~d; PAR_EN = ~pen; PAR_TYP = ~ptyp;
        repeat (DW + 4) @(posedge clk);
        #1;
        check("sb_empty", 32'(sb_q.size()), 32'd0);
    endtask

    // Bytes driven one per cycle while Data_Valid stays high; entry 11 is
    // the one present during the single IDLE cycle after the first frame.
    logic [DW-1:0] stream [12] = '{8'h3C, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55,
                                   8'h66, 8'h77, 8'h99, 8'hAA, 8'hBB, 8'h81};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; P_DATA = '0; Data_Valid = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        #12;
        check("rst_sel",  32'(mux_sel),  32'd1);
        check("rst_busy", 32'(busy),     32'd0);
        check("rst_ser",  32'(ser_data), 32'd0);
        check("rst_par",  32'(par_bit),  32'd0);
        @(posedge clk); #1; rst = 1'b1;

        // 1: idle after reset
        repeat (5) begin
            @(posedge clk); #1;
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_mux",  32'(mux_sel), 32'd1);
        end

        // 2, 3: single frames with and without parity
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b1, 1'b1, 1'b1);
        send_frame(8'h07, 1'b1, 1'b0, 1'b1);
        check("par_hold", 32'(par_bit), 32'd1);

        // 4: Data_Valid held high, data changing every cycle
        push_frame(8'h3C, 1'b0, 1'b0, -1);
        push_frame(8'h81, 1'b0, 1'b0, 1);
        PAR_EN = 1'b0; PAR_TYP = 1'b0;
        for (int k = 0; k < 12; k++) begin
            P_DATA = stream[k]; Data_Valid = 1'b1;
            @(posedge clk); #1;
        end
        Data_Valid = 1'b0; P_DATA = 8'hFF;
        repeat (DW + 4) @(posedge clk);
        #1;
        check("stream_sb_empty", 32'(sb_q.size()), 32'd0);

        // 5: reset during the 4th DATA cycle of 0xFF
        push(2'b00, 1'b0, 1'b0, 1'b0, -1);
        for (int i = 0; i < 4; i++) push(2'b10, 1'b1, 1'b1, 1'b0, -1);
        P_DATA = 8'hFF; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_Valid = 1'b1;
        @(posedge clk); #1;
        Data_Valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk); #1;
        rst = 1'b0;
        #1;
        check("midrst_sel",  32'(mux_sel), 32'd1);
        check("midrst_busy", 32'(busy),    32'd0);
        check("midrst_par",  32'(par_bit), 32'd0);
        check("midrst_sb_empty", 32'(sb_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1; rst = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            check("post_rst_busy", 32'(busy), 32'd0);
        end

        // 6: Data_Valid pulse in the STOP cycle is dropped
        push_frame(8'h5A, 1'b0, 1'b0, -1);
        P_DATA = 8'h5A; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_Valid = 1'b1;
        @(posedge clk); #1;
        Data_Valid = 1'b0; P_DATA = 8'hC3;
        repeat (DW + 1) @(posedge clk);
        #1; Data_Valid = 1'b1;
        @(posedge clk); #1; Data_Valid = 1'b0;
        repeat (DW + 6) @(posedge clk);
        #1;
        check("stop_dv_busy", 32'(busy), 32'd0);
        check("stop_dv_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
